// File: rtl/alu_regfile_wb_if.sv
// Bus between the ALU datapath and the operand register file / write-back stage.
// The master side drives the read selects and write-back requests and receives
// the operands, the architectural flags and the write-back pending indication.
interface alu_regfile_wb_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REGS   = 8
);
    localparam int ADDR_WIDTH = $clog2(NUM_REGS);

    logic [ADDR_WIDTH-1:0] rd_addr_a;
    logic [ADDR_WIDTH-1:0] rd_addr_b;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  flags_en;
    logic                  alu_carry;
    logic                  alu_overflow;
    logic [3:0]            flags;
    logic                  wb_pending;

    modport master (
        output rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data,
               flags_en, alu_carry, alu_overflow,
        input  op_a, op_b, flags, wb_pending
    );

    modport slave (
        input  rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data,
               flags_en, alu_carry, alu_overflow,
        output op_a, op_b, flags, wb_pending
    );
endinterface

// File: rtl/alu_regfile_wb.sv
// Operand register file with a one-deep write-back register in front of it.
// A result issued in cycle t is captured into the write-back register, forwarded
// to both read ports and the flags output in cycle t+1, and committed to the
// array / NVCZ flags register on the following edge.
module alu_regfile_wb #(
    parameter int  DATA_WIDTH = 8,
    parameter int  NUM_REGS   = 8,
    localparam int ADDR_WIDTH = $clog2(NUM_REGS)
) (
    input logic              clk,
    input logic              rst_n,
    alu_regfile_wb_if.slave  bus
);

    if (NUM_REGS < 2 || (NUM_REGS & (NUM_REGS - 1)) != 0) begin : g_bad_num_regs
        $error("alu_regfile_wb: NUM_REGS must be a power of two and at least 2");
    end

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic [3:0]            flags_q, flags_d;
    logic                  wb_valid_q, wb_valid_d;
    logic                  wb_fvalid_q, wb_fvalid_d;
    logic [ADDR_WIDTH-1:0] wb_addr_q, wb_addr_d;
    logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
    logic [3:0]            wb_flags_q, wb_flags_d;

    // Next state: commit the older write-back entry while capturing the newer request.
    always_comb begin
        regs_d      = regs_q;
        flags_d     = flags_q;
        wb_valid_d  = bus.wr_en;
        wb_fvalid_d = bus.flags_en;
        wb_addr_d   = wb_addr_q;
        wb_data_d   = wb_data_q;
        wb_flags_d  = wb_flags_q;

        if (wb_valid_q) begin
            regs_d[wb_addr_q] = wb_data_q;
        end
        if (wb_fvalid_q) begin
            flags_d = wb_flags_q;
        end
        if (bus.wr_en) begin
            wb_addr_d = bus.wr_addr;
            wb_data_d = bus.wr_data;
        end
        if (bus.flags_en) begin
            wb_flags_d = {bus.wr_data[DATA_WIDTH-1], bus.alu_overflow,
                          bus.alu_carry, (bus.wr_data == '0)};
        end
    end

    // State registers; reset discards any pending write-back without committing it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q      <= '{default: '0};
            flags_q     <= '0;
            wb_valid_q  <= 1'b0;
            wb_fvalid_q <= 1'b0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
            wb_flags_q  <= '0;
        end else begin
            regs_q      <= regs_d;
            flags_q     <= flags_d;
            wb_valid_q  <= wb_valid_d;
            wb_fvalid_q <= wb_fvalid_d;
            wb_addr_q   <= wb_addr_d;
            wb_data_q   <= wb_data_d;
            wb_flags_q  <= wb_flags_d;
        end
    end

    // Read ports see the pending write-back value ahead of the array; the
    // same-cycle write request is deliberately not forwarded.
    always_comb begin
        bus.op_a = regs_q[bus.rd_addr_a];
        bus.op_b = regs_q[bus.rd_addr_b];
        if (wb_valid_q && wb_addr_q == bus.rd_addr_a) begin
            bus.op_a = wb_data_q;
        end
        if (wb_valid_q && wb_addr_q == bus.rd_addr_b) begin
            bus.op_b = wb_data_q;
        end
    end

    // Architectural flags view and pending indication.
    always_comb begin
        bus.flags      = wb_fvalid_q ? wb_flags_q : flags_q;
        bus.wb_pending = wb_valid_q | wb_fvalid_q;
    end

endmodule

// File: tb/tb_alu_regfile_wb.sv
// Directed bench for alu_regfile_wb: a reference model of the architectural
// register/flags state produces the expected view for each issued step, which
// is queued and compared once the DUT has taken the clock edge.
`timescale 1ns/1ps
module tb_alu_regfile_wb;

    typedef struct {
        string      tag;
        logic [7:0] op_a;
        logic [7:0] op_b;
        logic [3:0] flags;
        logic       pending;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    logic [7:0] mregs [8];
    logic [3:0] mflags;
    exp_t       sb_q [$];

    alu_regfile_wb_if #(.DATA_WIDTH(8), .NUM_REGS(8)) bus ();

    alu_regfile_wb #(.DATA_WIDTH(8), .NUM_REGS(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequence never completes.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed=timeout expected=completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic popAndCheck();
        exp_t e;
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboard_empty: observed=0 entries expected=1 entry");
        end else begin
            e = sb_q.pop_front();
            checkOutput({e.tag, ":op_a"}, bus.op_a, e.op_a);
            checkOutput({e.tag, ":op_b"}, bus.op_b, e.op_b);
            checkOutput({e.tag, ":flags"}, {4'h0, bus.flags}, {4'h0, e.flags});
            checkOutput({e.tag, ":pending"}, {7'h0, bus.wb_pending}, {7'h0, e.pending});
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 8; i++) mregs[i] = 8'h00;
        mflags = 4'h0;
        sb_q.delete();
    endtask

    // Reads every register through both ports within a few ns, no clock edge involved.
    task automatic checkAllZero(input string tag);
        for (int i = 0; i < 4; i++) begin
            bus.rd_addr_a = 3'(2 * i);
            bus.rd_addr_b = 3'(2 * i + 1);
            #0.4;
            checkOutput({tag, ":op_a"}, bus.op_a, 8'h00);
            checkOutput({tag, ":op_b"}, bus.op_b, 8'h00);
        end
        checkOutput({tag, ":flags"}, {4'h0, bus.flags}, 8'h00);
        checkOutput({tag, ":pending"}, {7'h0, bus.wb_pending}, 8'h00);
    endtask

    // One cycle: drive a request, confirm it is not visible yet, queue the
    // expected next-cycle view, clock it in and compare.
    task automatic applyStimulus(input string tag, input logic we, input logic [2:0] wa,
                                 input logic [7:0] wd, input logic fe, input logic c,
                                 input logic v, input logic [2:0] ra, input logic [2:0] rb);
        exp_t e;
        bus.wr_en        = we;
        bus.wr_addr      = wa;
        bus.wr_data      = wd;
        bus.flags_en     = fe;
        bus.alu_carry    = c;
        bus.alu_overflow = v;
        bus.rd_addr_a    = ra;
        bus.rd_addr_b    = rb;
        #1;
        checkOutput({tag, ":pre_a"}, bus.op_a, mregs[ra]);
        checkOutput({tag, ":pre_b"}, bus.op_b, mregs[rb]);
        checkOutput({tag, ":pre_flags"}, {4'h0, bus.flags}, {4'h0, mflags});
        if (we) mregs[wa] = wd;
        if (fe) mflags = {wd[7], v, c, (wd == 8'h00)};
        e.tag     = tag;
        e.op_a    = mregs[ra];
        e.op_b    = mregs[rb];
        e.flags   = mflags;
        e.pending = we | fe;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        bus.wr_en    = 1'b0;
        bus.flags_en = 1'b0;
        popAndCheck();
    endtask

    task automatic idle(input string tag, input logic [2:0] ra, input logic [2:0] rb);
        applyStimulus(tag, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, ra, rb);
    endtask

    // Directed sequence.
    initial begin
        total = 0;
        bad   = 0;
        modelReset();
        rst_n            = 1'b0;
        bus.rd_addr_a    = '0;
        bus.rd_addr_b    = '0;
        bus.wr_en        = 1'b0;
        bus.wr_addr      = '0;
        bus.wr_data      = '0;
        bus.flags_en     = 1'b0;
        bus.alu_carry    = 1'b0;
        bus.alu_overflow = 1'b0;
        #0.5;
        checkAllZero("por");
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        idle("idle0", 3'd0, 3'd0);

        // Forwarding then array commit of a single write.
        applyStimulus("w_r3", 1'b1, 3'd3, 8'h5A, 1'b0, 1'b0, 1'b0, 3'd3, 3'd0);
        idle("r3_array", 3'd3, 3'd0);

        // Back-to-back writes to the same register.
        applyStimulus("w_r2_11", 1'b1, 3'd2, 8'h11, 1'b0, 1'b0, 1'b0, 3'd0, 3'd2);
        applyStimulus("w_r2_22", 1'b1, 3'd2, 8'h22, 1'b0, 1'b0, 1'b0, 3'd0, 3'd2);
        idle("r2_hold1", 3'd0, 3'd2);
        idle("r2_hold2", 3'd2, 3'd2);

        // Flag formation and the write-only / flags-only variants.
        applyStimulus("fl_zc", 1'b1, 3'd4, 8'h00, 1'b1, 1'b1, 1'b0, 3'd4, 3'd3);
        applyStimulus("fl_nv", 1'b1, 3'd6, 8'h80, 1'b1, 1'b0, 1'b1, 3'd4, 3'd6);
        idle("fl_hold", 3'd6, 3'd4);
        applyStimulus("wr_only", 1'b1, 3'd1, 8'h3C, 1'b0, 1'b1, 1'b1, 3'd1, 3'd6);
        applyStimulus("fl_only", 1'b0, 3'd3, 8'h00, 1'b1, 1'b0, 1'b0, 3'd3, 3'd2);
        idle("fl_only_hold", 3'd1, 3'd3);

        // Every address written, with mixed flag updates.
        for (int i = 0; i < 8; i++) begin
            applyStimulus($sformatf("sweep%0d", i), 1'b1, 3'(i), 8'($urandom_range(0, 255)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 3'(i), 3'((i + 7) % 8));
        end
        idle("sweep_end", 3'd7, 3'd0);

        // Reset while a write is still pending: it must never reach the array.
        applyStimulus("w_r5", 1'b1, 3'd5, 8'hFF, 1'b1, 1'b1, 1'b1, 3'd5, 3'd5);
        rst_n = 1'b0;
        #0.5;
        rst_n = 1'b1;
        modelReset();
        #0.5;
        checkAllZero("rst_pending");
        idle("r5_after1", 3'd5, 3'd5);
        idle("r5_after2", 3'd5, 3'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
